cic_seq: RTL

Run controller for the decimating CIC datapath (Win=18, Wout=16, R=2000, K=2). It paces input samples with a programmable strobe and holds the CIC in reset between runs. It discards the CIC start-up transient and forwards a burst of decimated outputs downstream. It also checks that the CIC produces exactly one output per R input strobes.

---
 rtl/cic_seq_pkg.sv | 19 +
 rtl/cic_seq_strobe_gen.sv | 38 +++
 rtl/cic_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cic_seq_pkg.sv
// Shared types and constants for the CIC run controller.
package cic_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam int DEF_DIV    = 4;
    localparam int DEF_R      = 2000;
    localparam int DEF_SETTLE = 2;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cic_seq_strobe_gen.sv
// Input-sample strobe divider: one strobe every DIV enabled clocks.
module cic_strobe_gen
    import cic_seq_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ic_en,
    input  logic ic_clr,
    output logic oc_strb
);

    localparam int DW = cnt_w(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (ic_clr) begin
            div_d = '0;
        end else if (ic_en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign oc_strb = ic_en && !ic_clr && (div_q == DIV_LAST);

endmodule

// File: rtl/cic_seq.sv
// Run controller for a decimating CIC: paces input strobes, discards the
// start-up transient, forwards output bursts and checks output phase.
module cic_seq
    import cic_seq_pkg::*;
#(
    parameter int DIV    = DEF_DIV,
    parameter int R      = DEF_R,
    parameter int SETTLE = DEF_SETTLE,
    parameter int NBURST = 0,
    parameter int W      = 16
) (
    input  logic         clk,
    input  logic         ic_rst_n,
    input  logic         ic_start,
    input  logic         ic_stop,
    output logic         oc_cic_rst,
    output logic         oc_cic_val,
    input  logic         ic_cic_val,
    input  logic [W-1:0] id_cic_data,
    output logic [W-1:0] od_data,
    output logic         oc_val_data,
    output logic         oc_busy,
    output logic         oc_done,
    output logic         oc_err
);

    localparam int PW = cnt_w(R + 2);
    localparam int SW = cnt_w(SETTLE + 1);
    localparam int BW = cnt_w(NBURST + 1);

    localparam logic [PW-1:0] PH_R     = PW'(R);
    localparam logic [PW-1:0] PH_SAT   = PW'(R + 1);
    localparam logic [SW-1:0] SET_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [BW-1:0] NB_LAST  = BW'((NBURST > 0) ? NBURST - 1 : 0);
    localparam bit            BURST_MODE = (NBURST > 0);

    state_t        state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [SW-1:0] set_q, set_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          err_q, err_d;
    logic [W-1:0]  data_q, data_d;
    logic          val_q, val_d;
    logic          done_q, done_d;

    logic strb, strb_en, strb_clr;
    logic idle, busy_st, start_ok, val_ok, fwd, last_fwd, settle_last;

    function automatic logic [BW-1:0] burst_inc(input logic [BW-1:0] v);
        return (v == {BW{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ph_inc(input logic [PW-1:0] v);
        return (v >= PH_SAT) ? PH_SAT : v + 1'b1;
    endfunction

    // The cycle carrying oc_done still counts as busy, so a new run can only
    // start once the CIC has seen at least one reset cycle.
    assign busy_st     = (state_q != ST_IDLE);
    assign idle        = !busy_st && !done_q;
    assign start_ok    = idle && ic_start && !ic_stop;
    assign val_ok      = ic_cic_val && busy_st && !ic_stop;
    assign fwd         = val_ok && (state_q == ST_RUN);
    assign last_fwd    = fwd && BURST_MODE && (burst_q == NB_LAST);
    assign settle_last = val_ok && (state_q == ST_SETTLE) && (set_q == SET_LAST);

    cic_strobe_gen #(
        .DIV(DIV)
    ) u_strobe (
        .clk    (clk),
        .rst_n  (ic_rst_n),
        .ic_en  (strb_en),
        .ic_clr (strb_clr),
        .oc_strb(strb)
    );

    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = (SETTLE > 0) ? ST_SETTLE : ST_RUN;
                end
            end
            ST_SETTLE: begin
                if (ic_stop) begin
                    state_d = ST_IDLE;
                end else if (settle_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ic_stop || last_fwd) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        strb_en    = busy_st;
        strb_clr   = start_ok;
        oc_busy    = busy_st || done_q;
        oc_cic_rst = !(busy_st || done_q);
    end

    assign oc_cic_val = strb;

    always_comb begin
        set_d   = set_q;
        burst_d = burst_q;
        ph_d    = ph_q;
        err_d   = err_q;
        if (start_ok) begin
            set_d   = '0;
            burst_d = '0;
            ph_d    = '0;
            err_d   = 1'b0;
        end else if (busy_st) begin
            if (val_ok && (state_q == ST_SETTLE)) begin
                set_d = set_q + 1'b1;
            end
            if (fwd) begin
                burst_d = burst_inc(burst_q);
            end
            // Phase check: exactly R strobes must separate consecutive outputs.
            if (ic_cic_val) begin
                ph_d = strb ? PW'(1) : '0;
                if (ph_q != PH_R) begin
                    err_d = 1'b1;
                end
            end else if (strb) begin
                if (ph_q == PH_R) begin
                    err_d = 1'b1;
                end
                ph_d = ph_inc(ph_q);
            end
        end
    end

    always_comb begin
        data_d = fwd ? id_cic_data : data_q;
        val_d  = fwd;
        done_d = last_fwd;
    end

    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            ph_q    <= '0;
            set_q   <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            val_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            set_q   <= set_d;
            burst_q <= burst_d;
            err_q   <= err_d;
            data_q  <= data_d;
            val_q   <= val_d;
            done_q  <= done_d;
        end
    end

    assign od_data     = data_q;
    assign oc_val_data = val_q;
    assign oc_done     = done_q;
    assign oc_err      = err_q;

endmodule
